// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_A_WIDTH = 5;
    localparam int unsigned DEF_D_WIDTH = 32;

    // Status register that trigger_in sets to 1.
    localparam logic [4:0] STATUS_REG = 5'd9;

    typedef struct packed {
        logic [DEF_A_WIDTH-1:0] addr;
        logic [DEF_D_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester bundle: per-requester valid/ready handshake with packed address and data.
interface rf_write_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned D_WIDTH = DEF_D_WIDTH
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_addr;
    logic [NUM_REQ*D_WIDTH-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);
    logic        found;
    int unsigned idx;

    // Scan N slots starting at ptr, wrapping, and grant the first requester found.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            for (int unsigned j = 0; j < N; j++) begin
                if (j == idx && !found && req[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between NUM_REQ writeback requesters,
// sequences the status-register trigger and exposes a pending-write scoreboard.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  wb,
    input  logic               trigger_in,
    input  logic [A_WIDTH-1:0] q_ad1,
    input  logic [A_WIDTH-1:0] q_ad2,
    output logic               q_hit1,
    output logic               q_hit2,
    output logic               we3,
    output logic [A_WIDTH-1:0] ad3,
    output logic [D_WIDTH-1:0] wd3,
    output logic               trigger_out,
    output logic               busy
);
    localparam int unsigned        PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [A_WIDTH-1:0] STATUS_ADDR = A_WIDTH'(STATUS_REG);

    logic [NUM_REQ-1:0] buf_v;
    logic [NUM_REQ-1:0] grant;
    logic [A_WIDTH-1:0] buf_addr [NUM_REQ];
    logic [D_WIDTH-1:0] buf_data [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic               gnt_any;
    logic [A_WIDTH-1:0] gnt_addr;
    logic [D_WIDTH-1:0] gnt_data;
    logic               trig_pend;
    logic               collision;
    logic               trig_issue;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req   (buf_v),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // A buffer accepts when empty or when it is being drained this cycle.
    assign wb.req_ready = {NUM_REQ{!rst}} & (~buf_v | grant);

    assign busy = (|buf_v) | trig_pend | we3;

    // Encode the winner, the next pointer and whether the trigger may issue now.
    always_comb begin
        gnt_any  = |grant;
        gnt_idx  = '0;
        gnt_addr = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = PTR_W'(i);
                gnt_addr = buf_addr[i];
                gnt_data = buf_data[i];
            end
        end
        ptr_next   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        // Trigger waits a cycle when a write to the status register issues on the same edge.
        collision  = gnt_any && (gnt_addr == STATUS_ADDR);
        trig_issue = trig_pend && !collision;
    end

    // Holding buffers: refill on accept (x0 writes dropped), clear when granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (wb.req_valid[i] && wb.req_ready[i] &&
                    wb.req_addr[i*A_WIDTH +: A_WIDTH] != '0) begin
                    buf_v[i]    <= 1'b1;
                    buf_addr[i] <= wb.req_addr[i*A_WIDTH +: A_WIDTH];
                    buf_data[i] <= wb.req_data[i*D_WIDTH +: D_WIDTH];
                end else if (grant[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Registered rf port, round-robin pointer and trigger sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3         <= 1'b0;
            ad3         <= '0;
            wd3         <= '0;
            trigger_out <= 1'b0;
            rr_ptr      <= '0;
            trig_pend   <= 1'b0;
        end else begin
            we3 <= gnt_any;
            if (gnt_any) begin
                ad3    <= gnt_addr;
                wd3    <= gnt_data;
                rr_ptr <= ptr_next;
            end
            trigger_out <= trig_issue;
            trig_pend   <= (trig_pend && !trig_issue) || trigger_in;
        end
    end

    // Scoreboard: buffered writes, the write on the rf port and a pending trigger all count.
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (buf_v[i] && buf_addr[i] == q_ad1) q_hit1 = 1'b1;
            if (buf_v[i] && buf_addr[i] == q_ad2) q_hit2 = 1'b1;
        end
        if (we3 && ad3 == q_ad1) q_hit1 = 1'b1;
        if (we3 && ad3 == q_ad2) q_hit2 = 1'b1;
        if (trig_pend && q_ad1 == STATUS_ADDR) q_hit1 = 1'b1;
        if (trig_pend && q_ad2 == STATUS_ADDR) q_hit2 = 1'b1;
        q_hit1 = q_hit1 && !rst && (q_ad1 != '0);
        q_hit2 = q_hit2 && !rst && (q_ad2 != '0);
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int unsigned N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger_in;
    logic [4:0]  q_ad1, q_ad2;
    logic        q_hit1, q_hit2, we3, trigger_out, busy;
    logic [4:0]  ad3;
    logic [31:0] wd3;

    rf_write_arbiter_if #(.NUM_REQ(N), .A_WIDTH(5), .D_WIDTH(32)) bus ();

    rf_write_arbiter #(.NUM_REQ(N), .A_WIDTH(5), .D_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (bus),
        .trigger_in  (trigger_in),
        .q_ad1       (q_ad1),
        .q_ad2       (q_ad2),
        .q_hit1      (q_hit1),
        .q_hit2      (q_hit2),
        .we3         (we3),
        .ad3         (ad3),
        .wd3         (wd3),
        .trigger_out (trigger_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: one pending-write queue per requester plus rf-port expectations.
    wb_req_t     pend [N][$];
    int unsigned m_ptr;
    bit          m_trig, m_we, m_tout, known;
    logic [4:0]  m_ad;
    logic [31:0] m_wd;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(m_ptr) + k) % N;
            if (pend[j].size() != 0) return j;
        end
        return -1;
    endfunction

    function automatic bit exp_hit(input logic [4:0] q);
        if (rst || q == 5'd0) return 1'b0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < pend[i].size(); k++)
                if (pend[i][k].addr == q) return 1'b1;
        if (m_we && m_ad == q) return 1'b1;
        if (m_trig && q == 5'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy();
        for (int i = 0; i < N; i++)
            if (pend[i].size() != 0) return 1'b1;
        return m_trig || m_we;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid[i]       = v;
        bus.req_addr[i*5 +: 5] = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'd0, 32'd0);
        trigger_in = 1'b0;
    endtask

    // Inputs are set at the falling edge; check, advance the model, then wait one cycle.
    task automatic cycle();
        int       w;
        bit [N-1:0] rdy;
        bit       tout;
        logic [4:0] a;
        #1;
        w = winner();
        for (int i = 0; i < N; i++) rdy[i] = !rst && (pend[i].size() == 0 || w == i);
        chk("req_ready", 64'(bus.req_ready), 64'(rdy));
        chk("q_hit1", 64'(q_hit1), 64'(exp_hit(q_ad1)));
        chk("q_hit2", 64'(q_hit2), 64'(exp_hit(q_ad2)));
        if (known) begin
            chk("we3", 64'(we3), 64'(m_we));
            chk("ad3", 64'(ad3), 64'(m_ad));
            chk("wd3", 64'(wd3), 64'(m_wd));
            chk("trigger_out", 64'(trigger_out), 64'(m_tout));
            chk("busy", 64'(busy), 64'(exp_busy()));
        end
        if (rst) begin
            for (int i = 0; i < N; i++) pend[i].delete();
            m_ptr = 0; m_trig = 0; m_we = 0; m_tout = 0; m_ad = '0; m_wd = '0;
            known = 1'b1;
        end else begin
            tout = m_trig && !(w >= 0 && pend[w][0].addr == 5'd9);
            if (w >= 0) begin
                m_we  = 1'b1;
                m_ad  = pend[w][0].addr;
                m_wd  = pend[w][0].data;
                void'(pend[w].pop_front());
                m_ptr = (w + 1) % N;
            end else begin
                m_we = 1'b0;
            end
            m_tout = tout;
            m_trig = (m_trig && !tout) || trigger_in;
            for (int i = 0; i < N; i++) begin
                a = bus.req_addr[i*5 +: 5];
                if (bus.req_valid[i] && rdy[i] && a != 5'd0)
                    pend[i].push_back('{addr: a, data: bus.req_data[i*32 +: 32]});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int c = 0; c < n; c++) cycle();
    endtask

    function automatic logic [4:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r <= 2) return 5'd9;
        return 5'($urandom_range(1, 15));
    endfunction

    initial begin
        known = 1'b0;
        q_ad1 = 5'd0;
        q_ad2 = 5'd0;
        idle_inputs();

        // Reset with every requester asserting valid.
        rst = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        set_req(2, 1'b1, 5'd3, 32'h33);
        cycle();
        cycle();
        rst = 1'b0;
        idle(1);

        // Single write to x5 with the scoreboard watching x5.
        q_ad1 = 5'd5;
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        idle(3);

        // Round-robin with all three requesters continuously valid.
        q_ad1 = 5'd10;
        q_ad2 = 5'd12;
        for (int c = 0; c < 7; c++) begin
            set_req(0, 1'b1, 5'd10, $urandom);
            set_req(1, 1'b1, 5'd11, $urandom);
            set_req(2, 1'b1, 5'd12, $urandom);
            cycle();
        end
        idle(4);

        // Write to x0 is accepted and dropped.
        q_ad1 = 5'd0;
        set_req(1, 1'b1, 5'd0, 32'h1234);
        cycle();
        idle(2);

        // Write to x9 colliding with a trigger request.
        q_ad1 = 5'd9;
        set_req(2, 1'b1, 5'd9, 32'h0);
        trigger_in = 1'b1;
        cycle();
        idle(4);

        // Reset while all three buffers hold writes.
        set_req(0, 1'b1, 5'd3, 32'hA);
        set_req(1, 1'b1, 5'd4, 32'hB);
        set_req(2, 1'b1, 5'd6, 32'hC);
        trigger_in = 1'b1;
        cycle();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(3);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 9) < 6), rand_addr(), $urandom);
            trigger_in = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 79) == 0);
            q_ad1      = 5'($urandom_range(0, 15));
            q_ad2      = ($urandom_range(0, 3) == 0) ? 5'd9 : 5'($urandom_range(0, 15));
            cycle();
        end
        rst = 1'b0;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
